// File: rtl/bg_vram_arbiter_if.sv
// Bus bundle between the GPU register decode / BG filler, the arbiter and the BG VRAM.
interface bg_vram_arbiter_if #(
  parameter int unsigned AW = 11,
  parameter int unsigned DW = 9
);
  // Display fetch port
  logic          disp_rd;
  logic [AW-1:0] disp_addr;
  logic [DW-1:0] disp_rdata;
  logic          disp_rvalid;
  // CPU write port
  logic          cpu_wr_req;
  logic [AW-1:0] cpu_wr_addr;
  logic [DW-1:0] cpu_wr_data;
  logic          cpu_wr_full;
  // CPU read port
  logic          cpu_rd_req;
  logic [AW-1:0] cpu_rd_addr;
  logic [DW-1:0] cpu_rd_data;
  logic          cpu_rd_done;
  logic          wr_overflow;
  // VRAM port
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic          ram_we;
  logic [DW-1:0] ram_dout;

  // Requesters and the VRAM instance
  modport master (
    output disp_rd, disp_addr, cpu_wr_req, cpu_wr_addr, cpu_wr_data,
           cpu_rd_req, cpu_rd_addr, ram_dout,
    input  disp_rdata, disp_rvalid, cpu_wr_full, cpu_rd_data, cpu_rd_done,
           wr_overflow, ram_addr, ram_din, ram_we
  );

  // Arbiter
  modport slave (
    input  disp_rd, disp_addr, cpu_wr_req, cpu_wr_addr, cpu_wr_data,
           cpu_rd_req, cpu_rd_addr, ram_dout,
    output disp_rdata, disp_rvalid, cpu_wr_full, cpu_rd_data, cpu_rd_done,
           wr_overflow, ram_addr, ram_din, ram_we
  );
endinterface

// File: rtl/bg_vram_arbiter.sv
// BG VRAM port arbiter: display fetch first, then a coherent CPU read, then buffered CPU writes.
module bg_vram_arbiter #(
  parameter int unsigned AW         = 11,
  parameter int unsigned DW         = 9,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  bg_vram_arbiter_if.slave bus
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_PEND = 2'd1,
    RD_WAIT = 2'd2,
    RD_DONE = 2'd3
  } rd_state_e;

  logic [AW-1:0] fifo_addr_q [FIFO_DEPTH];
  logic [DW-1:0] fifo_data_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          wr_overflow_q;
  logic          disp_rvalid_q;
  rd_state_e     state_q;
  logic          cpu_rd_done_q;
  logic [DW-1:0] cpu_rd_data_q;

  logic fifo_empty;
  logic fifo_full;
  logic grant_rd;
  logic pop;
  logic push;
  logic drop;

  // Grant decode; everything is qualified by rst so nothing reaches the VRAM during reset
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
  assign grant_rd   = rst && !bus.disp_rd && (state_q == RD_PEND) && fifo_empty;
  assign pop        = rst && !bus.disp_rd && !grant_rd && !fifo_empty;
  assign push       = rst && bus.cpu_wr_req && (!fifo_full || pop);
  assign drop       = rst && bus.cpu_wr_req && fifo_full && !pop;

  // VRAM port mux in strict priority order
  always_comb begin
    bus.ram_addr = bus.disp_addr;
    bus.ram_din  = fifo_data_q[rd_ptr_q];
    bus.ram_we   = 1'b0;
    if (bus.disp_rd) begin
      bus.ram_addr = bus.disp_addr;
    end else if (grant_rd) begin
      bus.ram_addr = bus.cpu_rd_addr;
    end else if (pop) begin
      bus.ram_addr = fifo_addr_q[rd_ptr_q];
      bus.ram_we   = 1'b1;
    end
  end

  // Write FIFO storage; contents need no reset since count gates every read
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr_q[wr_ptr_q] <= bus.cpu_wr_addr;
      fifo_data_q[wr_ptr_q] <= bus.cpu_wr_data;
    end
  end

  // FIFO pointers, occupancy, overflow flag and display valid pipe
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      wr_overflow_q <= 1'b0;
      disp_rvalid_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      if (push && !pop) begin
        count_q <= count_q + CW'(1);
      end else if (pop && !push) begin
        count_q <= count_q - CW'(1);
      end
      if (drop) wr_overflow_q <= 1'b1;
      disp_rvalid_q <= bus.disp_rd;
    end
  end

  // CPU read sequencer; RD_DONE holds until the request drops so a held request is not re-issued
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= IDLE;
      cpu_rd_done_q <= 1'b0;
      cpu_rd_data_q <= '0;
    end else begin
      cpu_rd_done_q <= 1'b0;
      unique case (state_q)
        IDLE:    if (bus.cpu_rd_req) state_q <= RD_PEND;
        RD_PEND: if (grant_rd) state_q <= RD_WAIT;
        RD_WAIT: begin
          cpu_rd_data_q <= bus.ram_dout;
          cpu_rd_done_q <= 1'b1;
          state_q       <= RD_DONE;
        end
        RD_DONE: if (!bus.cpu_rd_req) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.disp_rdata  = bus.ram_dout;
  assign bus.disp_rvalid = disp_rvalid_q;
  assign bus.cpu_wr_full = fifo_full;
  assign bus.cpu_rd_data = cpu_rd_data_q;
  assign bus.cpu_rd_done = cpu_rd_done_q;
  assign bus.wr_overflow = wr_overflow_q;

endmodule

// File: tb/tb_bg_vram_arbiter.sv
// Scoreboard bench for bg_vram_arbiter against a behavioural 1-cycle-latency VRAM.
module tb_bg_vram_arbiter;

  localparam int unsigned AW         = 11;
  localparam int unsigned DW         = 9;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned MEM_WORDS  = 1 << AW;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic init_mem = 1'b1;

  always #5 clk = ~clk;

  bg_vram_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  bg_vram_arbiter #(.AW(AW), .DW(DW), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // VRAM: preloaded with word = address, synchronous read
  logic [DW-1:0] vram [MEM_WORDS];
  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < int'(MEM_WORDS); i++) vram[i] <= DW'(i);
    end else if (bus.ram_we === 1'b1) begin
      vram[bus.ram_addr] <= bus.ram_din;
    end
    bus.ram_dout <= vram[bus.ram_addr];
  end

  wr_t           wq [$];
  logic [DW-1:0] dq [$];
  logic [DW-1:0] rq [$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_we_cyc = -1;
  int last_done_cyc = -1;
  int rvalid_seen = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Output monitor: pops the scoreboard queues as the DUT produces results
  always @(negedge clk) begin
    if (bus.disp_rvalid === 1'b1) begin
      rvalid_seen++;
      if (dq.size() == 0) check_eq("disp_unexpected", 32'(1), 32'(0));
      else check_eq("disp_rdata", 32'(bus.disp_rdata), 32'(dq.pop_front()));
    end
    if (bus.ram_we === 1'b1) begin
      wr_t e;
      last_we_cyc = cyc;
      check_eq("we_with_disp", 32'(bus.disp_rd), 32'(0));
      if (wq.size() == 0) begin
        check_eq("wr_unexpected", 32'(1), 32'(0));
      end else begin
        e = wq.pop_front();
        check_eq("wr_addr", 32'(bus.ram_addr), 32'(e.addr));
        check_eq("wr_data", 32'(bus.ram_din), 32'(e.data));
      end
    end
    if (bus.cpu_rd_done === 1'b1) begin
      last_done_cyc = cyc;
      if (rq.size() == 0) check_eq("rd_unexpected", 32'(1), 32'(0));
      else check_eq("rd_data", 32'(bus.cpu_rd_data), 32'(rq.pop_front()));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.disp_rd    = 1'b0;
    bus.cpu_wr_req = 1'b0;
    bus.cpu_rd_req = 1'b0;
  endtask

  task automatic drive_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input bit expect_accept);
    wr_t e;
    bus.cpu_wr_req  = 1'b1;
    bus.cpu_wr_addr = a;
    bus.cpu_wr_data = d;
    e.addr = a;
    e.data = d;
    if (expect_accept) wq.push_back(e);
  endtask

  // Issues a CPU read at posedge+1, checks latency, single pulse and held data
  task automatic cpu_read(input logic [AW-1:0] a, input logic [DW-1:0] e, input int lat);
    int n;
    bus.cpu_rd_req  = 1'b1;
    bus.cpu_rd_addr = a;
    rq.push_back(e);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      bus.cpu_wr_req = 1'b0;
      @(negedge clk);
      n++;
    end while (bus.cpu_rd_done !== 1'b1 && n < 40);
    check_eq("rd_done_seen", 32'(bus.cpu_rd_done), 32'(1));
    check_eq("rd_latency", 32'(n), 32'(lat));
    repeat (3) begin
      @(negedge clk);
      check_eq("rd_no_repulse", 32'(bus.cpu_rd_done), 32'(0));
    end
    check_eq("rd_data_held", 32'(bus.cpu_rd_data), 32'(e));
    step();
    bus.cpu_rd_req = 1'b0;
    step();
  endtask

  initial begin
    bus.disp_addr   = '0;
    bus.cpu_wr_addr = '0;
    bus.cpu_wr_data = '0;
    bus.cpu_rd_addr = '0;

    // Reset with every request asserted
    rst = 1'b0;
    bus.disp_rd    = 1'b1;
    bus.cpu_wr_req = 1'b1;
    bus.cpu_rd_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      init_mem = 1'b0;
      @(negedge clk);
      check_eq("rst_we", 32'(bus.ram_we), 32'(0));
      check_eq("rst_rvalid", 32'(bus.disp_rvalid), 32'(0));
    end
    step();
    rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    check_eq("rel_we", 32'(bus.ram_we), 32'(0));
    check_eq("rel_rvalid", 32'(bus.disp_rvalid), 32'(0));
    check_eq("rel_full", 32'(bus.cpu_wr_full), 32'(0));
    check_eq("rel_ovf", 32'(bus.wr_overflow), 32'(0));
    check_eq("rel_done", 32'(bus.cpu_rd_done), 32'(0));
    check_eq("rel_rd_data", 32'(bus.cpu_rd_data), 32'(0));
    step();

    // Display only, addresses 0..9
    rvalid_seen = 0;
    for (int a = 0; a < 10; a++) begin
      bus.disp_rd   = 1'b1;
      bus.disp_addr = AW'(a);
      dq.push_back(DW'(a));
      step();
    end
    bus.disp_rd = 1'b0;
    step();
    step();
    check_eq("disp_count", 32'(rvalid_seen), 32'(10));
    check_eq("disp_drained", 32'(dq.size()), 32'(0));

    // Writes buffered behind a 20-cycle display burst
    for (int c = 0; c < 20; c++) begin
      bus.disp_rd   = 1'b1;
      bus.disp_addr = AW'(200 + c);
      dq.push_back(DW'(200 + c));
      bus.cpu_wr_req = 1'b0;
      if (c == 3) drive_write(AW'(5), DW'(9'h1AB), 1'b1);
      if (c == 4) drive_write(AW'(6), DW'(9'h0C3), 1'b1);
      @(negedge clk);
      check_eq("wd_full", 32'(bus.cpu_wr_full), 32'(0));
      step();
    end
    idle_inputs();
    check_eq("wd_pending", 32'(wq.size()), 32'(2));
    step();
    step();
    check_eq("wd_drained", 32'(wq.size()), 32'(0));

    // Overflow: five writes into a four-entry FIFO while the display holds the port
    for (int c = 0; c < 5; c++) begin
      bus.disp_rd   = 1'b1;
      bus.disp_addr = AW'(300 + c);
      dq.push_back(DW'(300 + c));
      drive_write(AW'(10 + c), DW'(9'h100 + c), c < 4);
      @(negedge clk);
      check_eq(c == 4 ? "ov_full" : "ov_not_full", 32'(bus.cpu_wr_full), c == 4 ? 32'(1) : 32'(0));
      check_eq("ov_flag_pre", 32'(bus.wr_overflow), 32'(0));
      step();
    end
    idle_inputs();
    @(negedge clk);
    check_eq("ov_flag_set", 32'(bus.wr_overflow), 32'(1));
    repeat (4) step();
    check_eq("ov_drained", 32'(wq.size()), 32'(0));
    check_eq("ov_flag_sticky", 32'(bus.wr_overflow), 32'(1));
    check_eq("ov_full_clear", 32'(bus.cpu_wr_full), 32'(0));
    cpu_read(AW'(10), DW'(9'h100), 3);
    cpu_read(AW'(13), DW'(9'h103), 3);
    cpu_read(AW'(14), DW'(14), 3);

    // Read-after-write in the same cycle
    drive_write(AW'(100), DW'(9'h155), 1'b1);
    cpu_read(AW'(100), DW'(9'h155), 4);
    check_eq("raw_wr_done", 32'(wq.size()), 32'(0));
    check_eq("raw_order", 32'(last_we_cyc < last_done_cyc), 32'(1));

    // Reset clears the sticky overflow
    rst = 1'b0;
    step();
    rst = 1'b1;
    @(negedge clk);
    check_eq("ovf_cleared", 32'(bus.wr_overflow), 32'(0));
    step();

    // Fill FIFO, then push on the same cycle the head pops
    for (int c = 0; c < 4; c++) begin
      bus.disp_rd   = 1'b1;
      bus.disp_addr = AW'(400 + c);
      dq.push_back(DW'(400 + c));
      drive_write(AW'(20 + c), DW'(9'h0A0 + c), 1'b1);
      step();
    end
    bus.disp_rd = 1'b0;
    drive_write(AW'(24), DW'(9'h0AA), 1'b1);
    @(negedge clk);
    check_eq("fp_full", 32'(bus.cpu_wr_full), 32'(1));
    step();
    bus.cpu_wr_req = 1'b0;
    @(negedge clk);
    check_eq("fp_ovf", 32'(bus.wr_overflow), 32'(0));
    repeat (5) step();
    check_eq("fp_drained", 32'(wq.size()), 32'(0));
    check_eq("fp_ovf_after", 32'(bus.wr_overflow), 32'(0));
    cpu_read(AW'(24), DW'(9'h0AA), 3);

    // Reset while a read is pending behind the display and a write is queued
    bus.disp_rd     = 1'b1;
    bus.disp_addr   = AW'(450);
    dq.push_back(DW'(450));
    drive_write(AW'(30), DW'(9'h1FF), 1'b0);
    bus.cpu_rd_req  = 1'b1;
    bus.cpu_rd_addr = AW'(30);
    step();
    bus.cpu_wr_req = 1'b0;
    for (int c = 1; c < 4; c++) begin
      bus.disp_addr = AW'(450 + c);
      dq.push_back(DW'(450 + c));
      step();
    end
    rst = 1'b0;
    idle_inputs();
    step();
    rst = 1'b1;
    repeat (6) begin
      @(negedge clk);
      check_eq("mr_no_done", 32'(bus.cpu_rd_done), 32'(0));
      step();
    end
    check_eq("mr_full", 32'(bus.cpu_wr_full), 32'(0));
    cpu_read(AW'(30), DW'(30), 3);

    check_eq("end_dq", 32'(dq.size()), 32'(0));
    check_eq("end_wq", 32'(wq.size()), 32'(0));
    check_eq("end_rq", 32'(rq.size()), 32'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
